cpu_reg_wb_scheduler: RTL and testbench

- Sequences all writes into the CPU register file.
- Tracks pending destination registers (scoreboard) and stalls issue on RAW/WAW hazards.
- Arbitrates three writeback sources (ALU, load/store unit, multiply/divide unit) onto the register file's two write ports.
- Sits between the execute units and the register file; its registered write outputs connect directly to the file's rd1/rd2 write ports.

---
 rtl/cpu_reg_wb_scheduler_if.sv | 60 ++++++
 rtl/cpu_reg_wb_scheduler.sv | 156 +++++++++++++++
 tb/tb_cpu_reg_wb_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_reg_wb_scheduler_if.sv
// Issue, writeback and register-file write bundle for cpu_reg_wb_scheduler.
// master = decode/execute side, slave = scheduler.
interface cpu_reg_wb_scheduler_if #(
   parameter int REG_COUNT = 16,
   parameter int REG_WIDTH = 16
);
   localparam int ADDR_WIDTH = $clog2(REG_COUNT);

   logic                  issue_valid;
   logic                  issue_ready;
   logic [ADDR_WIDTH-1:0] issue_rs1;
   logic [ADDR_WIDTH-1:0] issue_rs2;
   logic                  issue_rs1_en;
   logic                  issue_rs2_en;
   logic [ADDR_WIDTH-1:0] issue_rd;
   logic                  issue_rd_en;

   logic                  alu_wb_valid;
   logic                  lsu_wb_valid;
   logic                  mdu_wb_valid;
   logic                  alu_wb_ready;
   logic                  lsu_wb_ready;
   logic                  mdu_wb_ready;
   logic [ADDR_WIDTH-1:0] alu_wb_rd;
   logic [ADDR_WIDTH-1:0] lsu_wb_rd;
   logic [ADDR_WIDTH-1:0] mdu_wb_rd;
   logic [REG_WIDTH-1:0]  alu_wb_data;
   logic [REG_WIDTH-1:0]  lsu_wb_data;
   logic [REG_WIDTH-1:0]  mdu_wb_data;

   logic [ADDR_WIDTH-1:0] rd1;
   logic [ADDR_WIDTH-1:0] rd2;
   logic                  rd1_write_enable;
   logic                  rd2_write_enable;
   logic [REG_WIDTH-1:0]  rd1_write_data;
   logic [REG_WIDTH-1:0]  rd2_write_data;
   logic [REG_COUNT-1:0]  pending;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rs1_en,
      output issue_rs2_en, issue_rd, issue_rd_en,
      output alu_wb_valid, lsu_wb_valid, mdu_wb_valid,
      output alu_wb_rd, lsu_wb_rd, mdu_wb_rd,
      output alu_wb_data, lsu_wb_data, mdu_wb_data,
      input  issue_ready, alu_wb_ready, lsu_wb_ready, mdu_wb_ready,
      input  rd1, rd2, rd1_write_enable, rd2_write_enable,
      input  rd1_write_data, rd2_write_data, pending
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rs1_en,
      input  issue_rs2_en, issue_rd, issue_rd_en,
      input  alu_wb_valid, lsu_wb_valid, mdu_wb_valid,
      input  alu_wb_rd, lsu_wb_rd, mdu_wb_rd,
      input  alu_wb_data, lsu_wb_data, mdu_wb_data,
      output issue_ready, alu_wb_ready, lsu_wb_ready, mdu_wb_ready,
      output rd1, rd2, rd1_write_enable, rd2_write_enable,
      output rd1_write_data, rd2_write_data, pending
   );
endinterface

// File: rtl/cpu_reg_wb_scheduler.sv
// Register-file writeback scheduler: scoreboard, hazard stall, 3-to-2 arbiter.
// Optional macro SCOREBOARD_BYPASS_EN lets a committing write clear a hazard early.
module cpu_reg_wb_scheduler #(
   parameter int REG_COUNT = 16,
   parameter int REG_WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst,
   cpu_reg_wb_scheduler_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(REG_COUNT);

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [REG_WIDTH-1:0]  data_t;

   logic [REG_COUNT-1:0] pending_q, pending_d;
   logic [REG_COUNT-1:0] clr_vec, set_vec, pend_eff;
   logic                 rr_q, rr_d;
   addr_t                rd1_q, rd1_d, rd2_q, rd2_d;
   logic                 we1_q, we1_d, we2_q, we2_d;
   data_t                wd1_q, wd1_d, wd2_q, wd2_d;

   logic  alu_g, lsu_g, mdu_g, f_g, o_g;
   logic  f_v, o_v;
   addr_t f_rd, o_rd;
   data_t f_data, o_data;
   logic  hazard;

   // rr_q = 0 favours LSU, 1 favours MDU
   always_comb begin
      f_v    = rr_q ? bus.mdu_wb_valid : bus.lsu_wb_valid;
      f_rd   = rr_q ? bus.mdu_wb_rd    : bus.lsu_wb_rd;
      f_data = rr_q ? bus.mdu_wb_data  : bus.lsu_wb_data;
      o_v    = rr_q ? bus.lsu_wb_valid : bus.mdu_wb_valid;
      o_rd   = rr_q ? bus.lsu_wb_rd    : bus.mdu_wb_rd;
      o_data = rr_q ? bus.lsu_wb_data  : bus.mdu_wb_data;
   end

   always_comb begin
      alu_g = 1'b0;
      f_g   = 1'b0;
      o_g   = 1'b0;
      rd1_d = '0;
      we1_d = 1'b0;
      wd1_d = '0;
      rd2_d = '0;
      we2_d = 1'b0;
      wd2_d = '0;
      if (!rst) begin
         if (bus.alu_wb_valid) begin
            alu_g = 1'b1;
            rd1_d = bus.alu_wb_rd;
            wd1_d = bus.alu_wb_data;
            if (f_v) begin
               f_g = !(f_rd == bus.alu_wb_rd && f_rd != '0);
               rd2_d = f_rd;
               wd2_d = f_data;
            end else if (o_v) begin
               o_g = !(o_rd == bus.alu_wb_rd && o_rd != '0);
               rd2_d = o_rd;
               wd2_d = o_data;
            end
         end else if (f_v) begin
            f_g   = 1'b1;
            rd1_d = f_rd;
            wd1_d = f_data;
            o_g   = o_v && !(o_rd == f_rd && o_rd != '0);
            rd2_d = o_rd;
            wd2_d = o_data;
         end else if (o_v) begin
            o_g   = 1'b1;
            rd1_d = o_rd;
            wd1_d = o_data;
         end
         we1_d = (alu_g || f_g || o_g) && rd1_d != '0;
         we2_d = alu_g ? ((f_g || o_g) && rd2_d != '0)
                       : (f_g && o_g && rd2_d != '0);
         if (!we1_d) begin
            rd1_d = '0;
            wd1_d = '0;
         end
         if (!we2_d) begin
            rd2_d = '0;
            wd2_d = '0;
         end
      end
   end

   assign lsu_g = rr_q ? o_g : f_g;
   assign mdu_g = rr_q ? f_g : o_g;

   always_comb begin
      rr_d = rr_q;
      if (bus.lsu_wb_valid && bus.mdu_wb_valid && (lsu_g ^ mdu_g))
         rr_d = ~rr_q;
   end

   always_comb begin
      clr_vec = '0;
      if (we1_q) clr_vec[rd1_q] = 1'b1;
      if (we2_q) clr_vec[rd2_q] = 1'b1;
   end

`ifdef SCOREBOARD_BYPASS_EN
   assign pend_eff = pending_q & ~clr_vec;
`else
   assign pend_eff = pending_q;
`endif

   assign hazard = (bus.issue_rs1_en && pend_eff[bus.issue_rs1]) ||
                   (bus.issue_rs2_en && pend_eff[bus.issue_rs2]) ||
                   (bus.issue_rd_en  && pend_eff[bus.issue_rd]);

   always_comb begin
      set_vec = '0;
      if (bus.issue_valid && !hazard && bus.issue_rd_en &&
          bus.issue_rd != '0)
         set_vec[bus.issue_rd] = 1'b1;
      pending_d    = (pending_q & ~clr_vec) | set_vec;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         rr_q      <= 1'b0;
         rd1_q     <= '0;
         we1_q     <= 1'b0;
         wd1_q     <= '0;
         rd2_q     <= '0;
         we2_q     <= 1'b0;
         wd2_q     <= '0;
      end else begin
         pending_q <= pending_d;
         rr_q      <= rr_d;
         rd1_q     <= rd1_d;
         we1_q     <= we1_d;
         wd1_q     <= wd1_d;
         rd2_q     <= rd2_d;
         we2_q     <= we2_d;
         wd2_q     <= wd2_d;
      end
   end

   assign bus.issue_ready      = !hazard;
   assign bus.alu_wb_ready     = alu_g;
   assign bus.lsu_wb_ready     = lsu_g;
   assign bus.mdu_wb_ready     = mdu_g;
   assign bus.rd1              = rd1_q;
   assign bus.rd2              = rd2_q;
   assign bus.rd1_write_enable = we1_q;
   assign bus.rd2_write_enable = we2_q;
   assign bus.rd1_write_data   = wd1_q;
   assign bus.rd2_write_data   = wd2_q;
   assign bus.pending          = pending_q;
endmodule

// File: tb/tb_cpu_reg_wb_scheduler.sv
// Directed bench for cpu_reg_wb_scheduler: scoreboard, arbitration, reset.
// Expectations follow SCOREBOARD_BYPASS_EN when it is defined.
module tb_cpu_reg_wb_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   cpu_reg_wb_scheduler_if #(.REG_COUNT(16), .REG_WIDTH(16)) bus ();

   cpu_reg_wb_scheduler #(.REG_COUNT(16), .REG_WIDTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid  = 1'b0;
      bus.issue_rs1    = '0;
      bus.issue_rs2    = '0;
      bus.issue_rs1_en = 1'b0;
      bus.issue_rs2_en = 1'b0;
      bus.issue_rd     = '0;
      bus.issue_rd_en  = 1'b0;
      bus.alu_wb_valid = 1'b0;
      bus.lsu_wb_valid = 1'b0;
      bus.mdu_wb_valid = 1'b0;
      bus.alu_wb_rd    = '0;
      bus.lsu_wb_rd    = '0;
      bus.mdu_wb_rd    = '0;
      bus.alu_wb_data  = '0;
      bus.lsu_wb_data  = '0;
      bus.mdu_wb_data  = '0;
   endtask

   initial begin
      idle();
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_pending", 32'(bus.pending), 32'h0);
      chk("rst_we1", 32'(bus.rd1_write_enable), 32'h0);
      chk("rst_we2", 32'(bus.rd2_write_enable), 32'h0);
      chk("rst_rd1", 32'(bus.rd1), 32'h0);

      // issue rd=3
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 4'd3;
      bus.issue_rd_en = 1'b1;
      #1;
      chk("issue3_ready", 32'(bus.issue_ready), 32'h1);
      step();
      idle();
      #1;
      chk("issue3_pending", 32'(bus.pending), 32'h0008);

      // RAW stall on r3, ALU writes r3
      bus.issue_valid  = 1'b1;
      bus.issue_rs1    = 4'd3;
      bus.issue_rs1_en = 1'b1;
      bus.alu_wb_valid = 1'b1;
      bus.alu_wb_rd    = 4'd3;
      bus.alu_wb_data  = 16'h1234;
      #1;
      chk("raw_stall", 32'(bus.issue_ready), 32'h0);
      chk("alu3_ready", 32'(bus.alu_wb_ready), 32'h1);
      step();
      bus.alu_wb_valid = 1'b0;
      #1;
      chk("alu3_rd1", 32'(bus.rd1), 32'h3);
      chk("alu3_we1", 32'(bus.rd1_write_enable), 32'h1);
      chk("alu3_wd1", 32'(bus.rd1_write_data), 32'h1234);
      chk("alu3_pend_hold", 32'(bus.pending), 32'h0008);
`ifdef SCOREBOARD_BYPASS_EN
      chk("raw_bypass_ready", 32'(bus.issue_ready), 32'h1);
`else
      chk("raw_still_stall", 32'(bus.issue_ready), 32'h0);
`endif
      step();
      chk("alu3_we1_off", 32'(bus.rd1_write_enable), 32'h0);
      chk("alu3_pend_clr", 32'(bus.pending), 32'h0);
      chk("raw_release", 32'(bus.issue_ready), 32'h1);
      idle();

      // ALU+LSU+MDU, pointer at LSU
      bus.alu_wb_valid = 1'b1;
      bus.alu_wb_rd    = 4'd1;
      bus.alu_wb_data  = 16'h00a1;
      bus.lsu_wb_valid = 1'b1;
      bus.lsu_wb_rd    = 4'd2;
      bus.lsu_wb_data  = 16'h00b2;
      bus.mdu_wb_valid = 1'b1;
      bus.mdu_wb_rd    = 4'd4;
      bus.mdu_wb_data  = 16'h00c4;
      #1;
      chk("all1_alu", 32'(bus.alu_wb_ready), 32'h1);
      chk("all1_lsu", 32'(bus.lsu_wb_ready), 32'h1);
      chk("all1_mdu", 32'(bus.mdu_wb_ready), 32'h0);
      step();
      bus.alu_wb_valid = 1'b0;
      bus.lsu_wb_valid = 1'b0;
      #1;
      chk("all1_rd1", 32'(bus.rd1), 32'h1);
      chk("all1_wd1", 32'(bus.rd1_write_data), 32'h00a1);
      chk("all1_rd2", 32'(bus.rd2), 32'h2);
      chk("all1_we2", 32'(bus.rd2_write_enable), 32'h1);
      chk("all1_wd2", 32'(bus.rd2_write_data), 32'h00b2);
      chk("all1_mdu_late", 32'(bus.mdu_wb_ready), 32'h1);
      step();
      bus.mdu_wb_valid = 1'b0;
      #1;
      chk("all1_mdu_rd1", 32'(bus.rd1), 32'h4);
      chk("all1_mdu_wd1", 32'(bus.rd1_write_data), 32'h00c4);
      chk("all1_mdu_we2", 32'(bus.rd2_write_enable), 32'h0);

      // repeat: pointer now at MDU
      bus.alu_wb_valid = 1'b1;
      bus.lsu_wb_valid = 1'b1;
      bus.mdu_wb_valid = 1'b1;
      #1;
      chk("all2_mdu", 32'(bus.mdu_wb_ready), 32'h1);
      chk("all2_lsu", 32'(bus.lsu_wb_ready), 32'h0);
      step();
      bus.alu_wb_valid = 1'b0;
      bus.mdu_wb_valid = 1'b0;
      #1;
      chk("all2_rd2", 32'(bus.rd2), 32'h4);
      chk("all2_wd2", 32'(bus.rd2_write_data), 32'h00c4);
      chk("all2_lsu_late", 32'(bus.lsu_wb_ready), 32'h1);
      step();
      bus.lsu_wb_valid = 1'b0;
      #1;
      chk("all2_lsu_rd1", 32'(bus.rd1), 32'h2);
      idle();

      // same rd=5 on LSU and MDU, pointer at LSU
      bus.lsu_wb_valid = 1'b1;
      bus.lsu_wb_rd    = 4'd5;
      bus.lsu_wb_data  = 16'h0055;
      bus.mdu_wb_valid = 1'b1;
      bus.mdu_wb_rd    = 4'd5;
      bus.mdu_wb_data  = 16'h0066;
      #1;
      chk("conf_lsu", 32'(bus.lsu_wb_ready), 32'h1);
      chk("conf_mdu", 32'(bus.mdu_wb_ready), 32'h0);
      step();
      bus.lsu_wb_valid = 1'b0;
      #1;
      chk("conf_wd1", 32'(bus.rd1_write_data), 32'h0055);
      chk("conf_we2", 32'(bus.rd2_write_enable), 32'h0);
      chk("conf_mdu_late", 32'(bus.mdu_wb_ready), 32'h1);
      step();
      bus.mdu_wb_valid = 1'b0;
      #1;
      chk("conf_mdu_rd1", 32'(bus.rd1), 32'h5);
      chk("conf_mdu_wd1", 32'(bus.rd1_write_data), 32'h0066);

      // rd=0 writeback with r6 pending
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 4'd6;
      bus.issue_rd_en = 1'b1;
      step();
      idle();
      #1;
      chk("issue6_pending", 32'(bus.pending), 32'h0040);
      bus.alu_wb_valid = 1'b1;
      bus.alu_wb_rd    = 4'd0;
      bus.alu_wb_data  = 16'hffff;
      #1;
      chk("r0_ready", 32'(bus.alu_wb_ready), 32'h1);
      step();
      bus.alu_wb_valid = 1'b0;
      #1;
      chk("r0_we1", 32'(bus.rd1_write_enable), 32'h0);
      step();
      chk("r0_pending", 32'(bus.pending), 32'h0040);

      // reset right after a grant
      bus.alu_wb_valid = 1'b1;
      bus.alu_wb_rd    = 4'd7;
      bus.alu_wb_data  = 16'h0077;
      step();
      bus.alu_wb_valid = 1'b0;
      #1;
      chk("pre_rst_we1", 32'(bus.rd1_write_enable), 32'h1);
      rst = 1'b1;
      step();
      chk("mid_rst_we1", 32'(bus.rd1_write_enable), 32'h0);
      chk("mid_rst_wd1", 32'(bus.rd1_write_data), 32'h0);
      chk("mid_rst_pending", 32'(bus.pending), 32'h0);
      rst = 1'b0;
      step();
      chk("post_rst_we1", 32'(bus.rd1_write_enable), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
